// File: rtl/bus_change_monitor_pkg.sv
// Shared types and constants for the bus change monitor.
package bus_change_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  localparam logic KIND_INIT   = 1'b0;
  localparam logic KIND_CHANGE = 1'b1;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_TSW   = 16;

  // Record at the default widths; the top re-declares it at its own widths.
  typedef struct packed {
    logic                 kind;
    logic [DEF_TSW-1:0]   stamp;
    logic [DEF_WIDTH-1:0] prev;
    logic [DEF_WIDTH-1:0] value;
  } rec_t;

endpackage

// File: rtl/bus_change_monitor_rec_fifo.sv
// Record FIFO with a registered output slot. The presented record counts
// toward DEPTH, so the total occupancy (stored + presented) never exceeds DEPTH.
// A record written into an empty FIFO is presented one edge after the write.
module rec_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type item_t = bus_change_monitor_pkg::rec_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  item_t push_data,
  input  logic  pop_ready,
  output logic  out_valid,
  output item_t out_data,
  output logic  full,
  output logic  empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  item_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   mem_count;
  logic [AW:0]   total;
  logic          pop;
  logic          load;
  logic          push_ok;

  // Occupancy flags and per-edge handshake decisions.
  always_comb begin
    total   = mem_count + (AW+1)'(out_valid);
    full    = (total == (AW+1)'(DEPTH));
    empty   = (total == '0);
    pop     = out_valid && pop_ready;
    // Refill the output slot from storage only with entries already stored
    // before this edge; that is what gives the one-cycle presentation delay.
    load    = (mem_count != '0) && (!out_valid || pop);
    push_ok = push && (!full || pop);
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers, stored-entry count and the registered output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (load) begin
        rd_ptr    <= rd_ptr + AW'(1);
        out_data  <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      case ({push_ok, load})
        2'b10:   mem_count <= mem_count + (AW+1)'(1);
        2'b01:   mem_count <= mem_count - (AW+1)'(1);
        default: mem_count <= mem_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_change_monitor.sv
// Watches a bus and queues timestamped records: one initial snapshot when
// monitoring starts, then one record per value change. Records that do not
// fit in the FIFO are dropped and counted.
module bus_change_monitor
  import bus_change_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TSW   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] watch,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic             rec_kind,
  output logic [TSW-1:0]   rec_time,
  output logic [WIDTH-1:0] rec_prev,
  output logic [WIDTH-1:0] rec_value,
  output logic             overflow,
  output logic [7:0]       drop_count
);

  typedef struct packed {
    logic             kind;
    logic [TSW-1:0]   stamp;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] value;
  } mon_rec_t;

  state_t           state;
  logic [TSW-1:0]   ts;
  logic [WIDTH-1:0] last;
  logic             push;
  logic             full;
  logic             empty;
  logic             drop;
  mon_rec_t         push_rec;
  mon_rec_t         head;

  // Decide whether this edge produces a record and build it.
  always_comb begin
    push     = 1'b0;
    push_rec = '0;
    if (enable) begin
      case (state)
        PRIME: begin
          push           = 1'b1;
          push_rec.kind  = KIND_INIT;
          push_rec.stamp = ts;
          push_rec.prev  = watch;
          push_rec.value = watch;
        end
        RUN: begin
          if (watch != last) begin
            push           = 1'b1;
            push_rec.kind  = KIND_CHANGE;
            push_rec.stamp = ts;
            push_rec.prev  = last;
            push_rec.value = watch;
          end
        end
        default: push = 1'b0;
      endcase
    end
  end

  // A full FIFO always has its output slot occupied, so a pop this edge is
  // simply rec_ready while not empty.
  assign drop = push && full && !(rec_ready && !empty);

  // Monitor FSM, timestamp, last-value register and loss accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ts         <= '0;
      last       <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      ts <= ts + TSW'(1);
      if (!enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    state <= PRIME;
          PRIME:   state <= RUN;
          default: state <= RUN;
        endcase
      end
      if (push) last <= watch;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  rec_fifo #(
    .DEPTH  (DEPTH),
    .item_t (mon_rec_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rec),
    .pop_ready (rec_ready),
    .out_valid (rec_valid),
    .out_data  (head),
    .full      (full),
    .empty     (empty)
  );

  assign rec_kind  = head.kind;
  assign rec_time  = head.stamp;
  assign rec_prev  = head.prev;
  assign rec_value = head.value;

endmodule

// File: tb/tb_bus_change_monitor.sv
// Self-checking bench for bus_change_monitor: directed vector table, corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_bus_change_monitor;

  localparam int unsigned W = 4;
  localparam int unsigned D = 8;
  localparam int unsigned T = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, enable, rec_ready, rec_valid, rec_kind, overflow;
  logic [W-1:0] watch, rec_prev, rec_value;
  logic [T-1:0] rec_time;
  logic [7:0]   drop_count;

  logic         rst2, enable2, rec_ready2, rec_valid2, rec_kind2, overflow2;
  logic [3:0]   watch2, rec_prev2, rec_value2, rec_time2;
  logic [7:0]   drop_count2;

  bus_change_monitor #(.WIDTH(W), .DEPTH(D), .TSW(T)) dut (
    .clk(clk), .rst(rst), .enable(enable), .watch(watch),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
    .rec_time(rec_time), .rec_prev(rec_prev), .rec_value(rec_value),
    .overflow(overflow), .drop_count(drop_count)
  );

  bus_change_monitor #(.WIDTH(4), .DEPTH(8), .TSW(4)) dut2 (
    .clk(clk), .rst(rst2), .enable(enable2), .watch(watch2),
    .rec_valid(rec_valid2), .rec_ready(rec_ready2), .rec_kind(rec_kind2),
    .rec_time(rec_time2), .rec_prev(rec_prev2), .rec_value(rec_value2),
    .overflow(overflow2), .drop_count(drop_count2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of records; an entry becomes visible only once
  // it has sat in the queue across one full edge; capacity includes the head.
  typedef struct {
    bit          kind;
    int unsigned stamp;
    int unsigned prev;
    int unsigned value;
    int unsigned pedge;
  } mrec_t;

  mrec_t       q[$];
  int unsigned m_ts, m_last, m_streak, m_edges, m_drops;
  bit          m_ovf;

  int          pops_seen;
  int unsigned last_pop_value;
  bit          last_pop_kind;

  task automatic model_reset();
    q.delete();
    m_ts = 0; m_last = 0; m_streak = 0; m_edges = 0; m_drops = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    bit    vis;
    bit    do_push;
    mrec_t r;
    m_edges++;
    vis = (q.size() > 0) && (q[0].pedge < m_edges - 1);
    if (vis && rec_ready) void'(q.pop_front());
    do_push = 0;
    r = '{0, 0, 0, 0, 0};
    if (enable) begin
      // streak counts consecutive earlier enabled edges
      if (m_streak == 1) begin
        r.kind = 0; r.prev = watch; r.value = watch; do_push = 1;
      end else if (m_streak >= 2 && watch != m_last) begin
        r.kind = 1; r.prev = m_last; r.value = watch; do_push = 1;
      end
      if (do_push) m_last = watch;
      if (m_streak < 2) m_streak++;
    end else begin
      m_streak = 0;
    end
    if (do_push) begin
      r.stamp = m_ts;
      r.pedge = m_edges;
      if (q.size() < D) q.push_back(r);
      else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end
    m_ts = (m_ts + 1) % (1 << T);
  endtask

  task automatic model_compare();
    bit v;
    v = (q.size() > 0) && (q[0].pedge < m_edges);
    chk("model_valid", rec_valid, v);
    if (v) begin
      chk("model_kind", rec_kind, q[0].kind);
      chk("model_time", rec_time, q[0].stamp);
      chk("model_prev", rec_prev, q[0].prev);
      chk("model_value", rec_value, q[0].value);
    end
    chk("model_overflow", overflow, m_ovf);
    chk("model_drop_count", drop_count, m_drops);
  endtask

  // One clock: note any pop, advance the model at the edge, compare after it.
  task automatic step();
    if (rec_valid && rec_ready) begin
      pops_seen++;
      last_pop_value = rec_value;
      last_pop_kind  = rec_kind;
    end
    @(posedge clk);
    model_edge();
    #1;
    model_compare();
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  w;
    logic        rdy;
    logic        ev;
    logic        ek;
    int unsigned et;
    logic [3:0]  ep;
    logic [3:0]  eval;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 0, 4'h0, 4'h0};
    tbl[1] = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 0, 4'h0, 4'h0};
    tbl[2] = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 1, 4'h5, 4'h5};
    tbl[3] = '{1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 0, 4'h0, 4'h0};
    tbl[4] = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 3, 4'h5, 4'hA};
    tbl[5] = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 4, 4'hA, 4'h5};
    tbl[6] = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 0, 4'h0, 4'h0};
    tbl[7] = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 0, 4'h0, 4'h0};

    rst = 1; enable = 0; watch = '0; rec_ready = 0;
    rst2 = 1; enable2 = 0; watch2 = '0; rec_ready2 = 1;
    pops_seen = 0; last_pop_value = 0; last_pop_kind = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", rec_valid, 0);
    chk("reset_kind", rec_kind, 0);
    chk("reset_time", rec_time, 0);
    chk("reset_prev", rec_prev, 0);
    chk("reset_value", rec_value, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_drop_count", drop_count, 0);
    chk("reset_valid_dut2", rec_valid2, 0);
    rst = 0;

    // Initial snapshot, then a one-cycle glitch giving two change records.
    for (int i = 0; i < 8; i++) begin
      enable = tbl[i].en; watch = tbl[i].w; rec_ready = tbl[i].rdy;
      step();
      chk("vec_valid", rec_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("vec_kind", rec_kind, tbl[i].ek);
        chk("vec_time", rec_time, tbl[i].et);
        chk("vec_prev", rec_prev, tbl[i].ep);
        chk("vec_value", rec_value, tbl[i].eval);
      end
    end

    // Overflow: re-prime with no consumer, then ten changes.
    enable = 0; step();
    enable = 1; rec_ready = 0; watch = 4'h5;
    step(); step();
    for (int i = 0; i < 10; i++) begin
      watch = (i % 2 == 0) ? 4'hA : 4'h5;
      step();
      chk("hold_valid", rec_valid, 1);
      chk("hold_kind", rec_kind, 0);
      chk("hold_prev", rec_prev, 4'h5);
      chk("hold_value", rec_value, 4'h5);
    end
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop_count", drop_count, 3);

    // Full FIFO: push and pop on the same edge, then drain everything.
    watch = 4'hA; rec_ready = 1;
    step();
    chk("full_pushpop_no_drop", drop_count, 3);
    pops_seen = 0;
    repeat (9) step();
    chk("drain_count", pops_seen, 8);
    chk("drain_tail_value", last_pop_value, 4'hA);
    chk("drain_tail_kind", last_pop_kind, 1);
    chk("drain_empty", rec_valid, 0);

    // Reset between edges with three records queued.
    rec_ready = 0;
    watch = 4'h5; step();
    watch = 4'hA; step();
    watch = 4'h5; step();
    step();
    chk("pre_rst_valid", rec_valid, 1);
    #3 rst = 1;
    #1 chk("rst_async_valid", rec_valid, 0);
    chk("rst_async_overflow", overflow, 0);
    model_reset();
    #1 rst = 0;
    enable = 1; watch = 4'h3; rec_ready = 1;
    step(); step(); step();
    chk("post_rst_valid", rec_valid, 1);
    chk("post_rst_kind", rec_kind, 0);
    chk("post_rst_value", rec_value, 4'h3);
    chk("post_rst_time", rec_time, 1);

    // Randomized traffic, alternating light and heavy backpressure.
    for (int i = 0; i < 500; i++) begin
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 2) == 0) watch = 4'($urandom);
      if ((i / 100) % 2 == 0) rec_ready = ($urandom_range(0, 3) != 0);
      else rec_ready = ($urandom_range(0, 4) == 0);
      step();
    end

    // Drop counter saturation.
    enable = 1; rec_ready = 0;
    for (int i = 0; i < 300; i++) begin
      watch = watch ^ 4'hF;
      step();
    end
    chk("sat_drop_count", drop_count, 8'hFF);
    chk("sat_overflow", overflow, 1);

    // Timestamp wrap on the narrow instance: change lands at ts=17 -> 1.
    enable = 0; rec_ready = 1;
    rst2 = 0; enable2 = 1; watch2 = 4'h5; rec_ready2 = 1;
    for (int e = 1; e <= 17; e++) step();
    watch2 = 4'h6;
    step(); step();
    chk("wrap_valid", rec_valid2, 1);
    chk("wrap_kind", rec_kind2, 1);
    chk("wrap_time", rec_time2, 1);
    chk("wrap_prev", rec_prev2, 4'h5);
    chk("wrap_value", rec_value2, 4'h6);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
